// File: rtl/ai_core_dispatch_scheduler.sv
// Shares one AI compute core between requesters: round-robin grant,
// one op in flight, wake/idle power control and DVFS freeze.
module ai_core_dispatch_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int WAKE_CYCLES = 4,
  parameter int IDLE_CYCLES = 16,
  parameter int TIMEOUT     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_instr,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [31:0]           rsp_result,
  output logic                  rsp_error,
  output logic [31:0]           core_instr,
  output logic [31:0]           core_data,
  output logic                  core_power_enable,
  output logic [3:0]            core_dvfs_level,
  input  logic [31:0]           core_result,
  input  logic                  core_done,
  input  logic [3:0]            dvfs_level_in,
  output logic                  busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW = $clog2(WAKE_CYCLES + 1);
  localparam int DW = $clog2(IDLE_CYCLES + 1);
  localparam int EW = $clog2(TIMEOUT + 1);

  localparam logic [WW-1:0] WAKE_INIT = WW'(WAKE_CYCLES - 1);
  localparam logic [DW-1:0] IDLE_LAST = DW'(IDLE_CYCLES - 1);
  localparam logic [EW-1:0] TO_LAST   = EW'(TIMEOUT - 1);
  localparam logic [IW-1:0] REQ_LAST  = IW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_WAKE,
    S_ARB,
    S_EXEC,
    S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wake_q, wake_d;
  logic [DW-1:0] idle_q, idle_d;
  logic [EW-1:0] exec_q, exec_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   result_q, result_d;
  logic          error_q, error_d;
  logic [3:0]    dvfs_q, dvfs_d;

  logic          gnt_found;
  logic [IW-1:0] gnt_idx;
  logic [31:0]   g_instr;
  logic [31:0]   g_data;
  logic          g_legal;

  // Search starts at rr_q and wraps, so the last grantee goes last.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [IW:0] c;
      c = {1'b0, rr_q} + (IW+1)'(k);
      if (c >= (IW+1)'(NUM_REQ)) begin
        c = c - (IW+1)'(NUM_REQ);
      end
      if (!gnt_found && req_valid[c[IW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = c[IW-1:0];
      end
    end
  end

  always_comb begin
    g_instr = '0;
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == gnt_idx) begin
        g_instr = req_instr[32*i +: 32];
        g_data  = req_data[32*i +: 32];
      end
    end
    g_legal = (g_instr[3:0] >= 4'd1) &&
              (g_instr[3:0] <= 4'd4);
  end

  always_comb begin
    state_d   = state_q;
    wake_d    = wake_q;
    idle_d    = '0;
    exec_d    = exec_q;
    rr_d      = rr_q;
    idx_d     = idx_q;
    instr_d   = instr_q;
    data_d    = data_q;
    result_d  = result_q;
    error_d   = error_q;
    dvfs_d    = dvfs_q;
    req_ready = '0;
    unique case (state_q)
      S_OFF: begin
        dvfs_d = dvfs_level_in;
        if (|req_valid) begin
          state_d = S_WAKE;
          wake_d  = WAKE_INIT;
        end
      end
      S_WAKE: begin
        if (wake_q == '0) begin
          state_d = S_ARB;
        end else begin
          wake_d = wake_q - 1'b1;
        end
      end
      S_ARB: begin
        dvfs_d = dvfs_level_in;
        if (gnt_found) begin
          req_ready = NUM_REQ'(1) << gnt_idx;
          instr_d   = g_instr;
          data_d    = g_data;
          idx_d     = gnt_idx;
          rr_d      = (gnt_idx == REQ_LAST) ? '0 : gnt_idx + 1'b1;
          exec_d    = '0;
          if (g_legal) begin
            state_d = S_EXEC;
          end else begin
            result_d = '0;
            error_d  = 1'b1;
            state_d  = S_RESP;
          end
        end else if (idle_q == IDLE_LAST) begin
          state_d = S_OFF;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      S_EXEC: begin
        exec_d = exec_q + 1'b1;
        // First EXEC cycle sees the core's stale done register.
        if (exec_q != '0 && core_done) begin
          result_d = core_result;
          error_d  = 1'b0;
          state_d  = S_RESP;
        end else if (exec_q == TO_LAST) begin
          result_d = '0;
          error_d  = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready[idx_q]) begin
          state_d = S_ARB;
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_OFF;
      wake_q   <= '0;
      idle_q   <= '0;
      exec_q   <= '0;
      rr_q     <= '0;
      idx_q    <= '0;
      instr_q  <= '0;
      data_q   <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
      dvfs_q   <= '0;
    end else begin
      state_q  <= state_d;
      wake_q   <= wake_d;
      idle_q   <= idle_d;
      exec_q   <= exec_d;
      rr_q     <= rr_d;
      idx_q    <= idx_d;
      instr_q  <= instr_d;
      data_q   <= data_d;
      result_q <= result_d;
      error_q  <= error_d;
      dvfs_q   <= dvfs_d;
    end
  end

  assign rsp_valid = (state_q == S_RESP) ?
                     NUM_REQ'(1) << idx_q : '0;
  assign rsp_result        = result_q;
  assign rsp_error         = error_q;
  assign core_instr        = (state_q == S_EXEC) ? instr_q : '0;
  assign core_data         = (state_q == S_EXEC) ? data_q : '0;
  assign core_power_enable = (state_q != S_OFF);
  assign core_dvfs_level   = dvfs_q;
  assign busy = (state_q == S_WAKE) || (state_q == S_EXEC) ||
                (state_q == S_RESP);

endmodule

// File: tb/tb_ai_core_dispatch_scheduler.sv
// Directed bench for ai_core_dispatch_scheduler with a small
// registered core model (done after a set number of EXEC cycles).
module tb_ai_core_dispatch_scheduler;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_instr = '0;
  logic [32*N-1:0] req_data = '0;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready = '0;
  logic [31:0]     rsp_result;
  logic            rsp_error;
  logic [31:0]     core_instr;
  logic [31:0]     core_data;
  logic            core_power_enable;
  logic [3:0]      core_dvfs_level;
  logic [31:0]     core_result = '0;
  logic            core_done = 1'b0;
  logic [3:0]      dvfs_level_in = 4'd3;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;
  int lat = 1;
  int ex_n = 0;

  ai_core_dispatch_scheduler #(
    .NUM_REQ(N), .WAKE_CYCLES(4),
    .IDLE_CYCLES(16), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_instr(req_instr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_error(rsp_error),
    .core_instr(core_instr), .core_data(core_data),
    .core_power_enable(core_power_enable),
    .core_dvfs_level(core_dvfs_level),
    .core_result(core_result), .core_done(core_done),
    .dvfs_level_in(dvfs_level_in), .busy(busy)
  );

  always #5 clk = ~clk;

  // Core: done registered `lat` cycles into an op (0 = never).
  always @(posedge clk) begin
    if (core_instr != '0) begin
      ex_n        <= ex_n + 1;
      core_done   <= (lat != 0) && (ex_n + 1 == lat);
      core_result <= core_data << 1;
    end else begin
      ex_n      <= 0;
      core_done <= 1'b0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i,
                         input logic [31:0] ins,
                         input logic [31:0] dat);
    req_instr[32*i +: 32] = ins;
    req_data[32*i +: 32]  = dat;
    req_valid[i]          = 1'b1;
  endtask

  task automatic count_exec(output int n);
    n = 0;
    while (core_instr != '0 && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  int ng, nr, n;

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_pwr", 32'(core_power_enable), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rdy", 32'(req_ready), 0);
    chk("rst_rsp", 32'(rsp_valid), 0);
    chk("rst_dvfs", 32'(core_dvfs_level), 0);
    reset = 1'b0;

    // basic op with wake-up
    @(negedge clk);
    chk("t1_off", 32'(core_power_enable), 0);
    set_req(0, 32'h11, 32'd5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_wake_pwr", 32'(core_power_enable), 1);
      chk("t1_wake_rdy", 32'(req_ready), 0);
    end
    @(negedge clk);
    chk("t1_grant", 32'(req_ready), 32'b0001);
    @(negedge clk);
    req_valid = '0;
    chk("t1_cinstr", core_instr, 32'h11);
    chk("t1_cdata", core_data, 32'd5);
    @(negedge clk);
    chk("t1_exec2", core_instr, 32'h11);
    @(negedge clk);
    chk("t1_rsp", 32'(rsp_valid), 32'b0001);
    chk("t1_res", rsp_result, 32'd10);
    chk("t1_err", 32'(rsp_error), 0);
    chk("t1_resp_ci", core_instr, 0);
    @(negedge clk);
    chk("t1_hold", 32'(rsp_valid), 32'b0001);
    chk("t1_hold_res", rsp_result, 32'd10);
    rsp_ready = 4'b0001;
    @(negedge clk);
    rsp_ready = '0;
    chk("t1_done_rsp", 32'(rsp_valid), 0);
    chk("t1_done_busy", 32'(busy), 0);

    // idle power-down 16 cycles after entering ARB
    repeat (15) @(negedge clk);
    chk("idle_16_pwr", 32'(core_power_enable), 1);
    @(negedge clk);
    chk("idle_off", 32'(core_power_enable), 0);

    // round-robin fairness from a fresh reset
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      set_req(i, 32'h1 + 32'(i) + (32'(i) << 8), 32'(i + 1));
    end
    rsp_ready = '1;
    lat = 1;
    reset = 1'b0;
    ng = 0;
    nr = 0;
    for (int c = 0; c < 100 && ng < 6; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) nr++;
      if (req_ready != '0) begin
        chk("rr_grant", 32'(req_ready), 32'(1) << (ng % 4));
        ng++;
      end
    end
    chk("rr_count", ng, 6);
    @(negedge clk);
    req_valid = '0;
    for (int c = 0; c < 40 && busy; c++) begin
      if (rsp_valid != '0) nr++;
      @(negedge clk);
    end
    chk("rr_drain", 32'(busy), 0);
    chk("rr_rsps", nr, 6);

    // illegal class from requester 2
    rsp_ready = '0;
    set_req(2, 32'h7, 32'h55);
    #1;
    chk("ill_grant", 32'(req_ready), 32'b0100);
    @(negedge clk);
    req_valid = '0;
    chk("ill_ci", core_instr, 0);
    chk("ill_rsp", 32'(rsp_valid), 32'b0100);
    chk("ill_res", rsp_result, 0);
    chk("ill_err", 32'(rsp_error), 1);
    rsp_ready = 4'b1011;
    @(negedge clk);
    chk("ill_other_rdy", 32'(rsp_valid), 32'b0100);
    rsp_ready = 4'b0100;
    @(negedge clk);
    rsp_ready = '0;
    chk("ill_done", 32'(rsp_valid), 0);

    // timeout, with DVFS change during EXEC
    lat = 0;
    set_req(1, 32'h2, 32'd7);
    #1;
    chk("to_grant", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = '0;
    dvfs_level_in = 4'd9;
    count_exec(n);
    chk("to_cycles", n, 8);
    chk("to_rsp", 32'(rsp_valid), 32'b0010);
    chk("to_err", 32'(rsp_error), 1);
    chk("to_res", rsp_result, 0);
    chk("to_dvfs_frz", 32'(core_dvfs_level), 3);
    rsp_ready = 4'b0010;
    @(negedge clk);
    rsp_ready = '0;
    chk("to_dvfs_arb", 32'(core_dvfs_level), 3);
    @(negedge clk);
    chk("to_dvfs_new", 32'(core_dvfs_level), 9);

    // done on the last allowed EXEC cycle wins
    lat = 7;
    set_req(3, 32'h4, 32'h100);
    #1;
    chk("late_grant", 32'(req_ready), 32'b1000);
    @(negedge clk);
    req_valid = '0;
    count_exec(n);
    chk("late_cycles", n, 8);
    chk("late_rsp", 32'(rsp_valid), 32'b1000);
    chk("late_err", 32'(rsp_error), 0);
    chk("late_res", rsp_result, 32'h200);

    // request on the 16th idle cycle keeps power
    rsp_ready = 4'b1000;
    @(negedge clk);
    rsp_ready = '0;
    repeat (15) @(negedge clk);
    chk("edge_pwr", 32'(core_power_enable), 1);
    lat = 1;
    set_req(0, 32'h3, 32'd1);
    #1;
    chk("edge_grant", 32'(req_ready), 32'b0001);
    @(negedge clk);
    req_valid = '0;
    chk("edge_pwr2", 32'(core_power_enable), 1);
    chk("edge_ci", core_instr, 32'h3);
    rsp_ready = '1;
    for (int c = 0; c < 20 && busy; c++) @(negedge clk);
    chk("edge_drain", 32'(busy), 0);
    chk("edge_res", rsp_result, 32'd2);

    // reset mid-EXEC aborts silently
    lat = 0;
    set_req(0, 32'h1, 32'd3);
    @(negedge clk);
    req_valid = '0;
    chk("ab_ci", core_instr, 32'h1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("ab_pwr", 32'(core_power_enable), 0);
    chk("ab_ci0", core_instr, 0);
    chk("ab_cd0", core_data, 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_dvfs", 32'(core_dvfs_level), 0);
    chk("ab_res", rsp_result, 0);
    @(negedge clk);
    reset = 1'b0;
    nr = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid != '0 || req_ready != '0) nr++;
    end
    chk("ab_no_rsp", nr, 0);
    chk("ab_off", 32'(core_power_enable), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
